// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for a single-cycle CPU.
// Port A is instruction fetch and port B is data read/write. Both share one
// DEPTH x DATA_W array, and reads return one cycle later. An internal FSM
// zeroes the array after reset (CLEAR) and accepts a byte-wide program load
// (LOAD). busy holds the CPU off while either mode is active.
//
// Loader handshake: a beat transfers on a rising edge where ld_valid and
// ld_ready are both high. ld_ready is high exactly while the FSM is in LOAD.
// ld_valid may be asserted without waiting for ld_ready. ld_addr and ld_data
// must be stable while ld_valid is high.
module cpu_mem_responder #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] instr_out,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic [DATA_W-1:0] write_data_b,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              ld_mode,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              ld_pend_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] data_b_q;
  logic              busy_q;
  logic              ld_ready_q;
  logic [ADDR_W:0]   ld_count_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              ld_accept_d;
  logic              collide_d;
  logic [DATA_W-1:0] rd_a_d;
  logic [DATA_W-1:0] rd_b_d;

  // A loader beat transfers only while LOAD is active.
  assign ld_accept_d = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

  // Reads are write-first. A port B write in this cycle is forwarded to any
  // port that reads the same address.
  assign collide_d = we_b && (addr_a == addr_b);
  assign rd_a_d    = collide_d ? write_data_b : mem_q[addr_a];
  assign rd_b_d    = we_b ? write_data_b : mem_q[addr_b];

  // Select the single array write port: clear sweep, CPU store, or loader
  // beat. Reset blocks every write.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = addr_b;
    mem_wdata_d = write_data_b;
    if (!rst) begin
      case (state_q)
        ST_CLEAR: begin
          mem_we_d    = 1'b1;
          mem_waddr_d = clr_ptr_q;
          mem_wdata_d = '0;
        end
        ST_RUN: begin
          mem_we_d = we_b;
        end
        ST_LOAD: begin
          mem_we_d    = ld_accept_d;
          mem_waddr_d = ld_addr;
          mem_wdata_d = ld_data;
        end
        default: mem_we_d = 1'b0;
      endcase
    end
  end

  // Shared storage array. It has no reset; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Mode FSM with registered read data, busy, ld_ready and the load counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      ld_pend_q  <= 1'b0;
      instr_q    <= NOP_WORD;
      data_b_q   <= '0;
      busy_q     <= 1'b1;
      ld_ready_q <= 1'b0;
      ld_count_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          instr_q   <= NOP_WORD;
          data_b_q  <= '0;
          clr_ptr_q <= clr_ptr_q + 1'b1;
          // A load request seen during the sweep is remembered for RUN.
          if (ld_mode) begin
            ld_pend_q <= 1'b1;
          end
          if (clr_ptr_q == CLR_LAST) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ld_mode || ld_pend_q) begin
            // The store on this edge still lands; outputs go quiet for LOAD.
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b1;
            ld_count_q <= '0;
            ld_pend_q  <= 1'b0;
            instr_q    <= NOP_WORD;
            data_b_q   <= '0;
          end else begin
            instr_q  <= rd_a_d;
            data_b_q <= rd_b_d;
          end
        end
        ST_LOAD: begin
          instr_q  <= NOP_WORD;
          data_b_q <= '0;
          if (ld_accept_d && (ld_count_q != COUNT_MAX)) begin
            ld_count_q <= ld_count_q + 1'b1;
          end
          // A beat on the exit cycle is still accepted above.
          if (!ld_mode) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b0;
            ld_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          clr_ptr_q  <= '0;
          busy_q     <= 1'b1;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_out  = instr_q;
  assign data_out_b = data_b_q;
  assign busy       = busy_q;
  assign ld_ready   = ld_ready_q;
  assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed steps plus randomized traffic,
// checked against a word-array reference model of the memory.
`timescale 1ns/1ps
module tb_cpu_mem_responder;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] addr_a = '0;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] addr_b = '0;
  logic          we_b = 1'b0;
  logic [DW-1:0] write_data_b = '0;
  logic [DW-1:0] data_out_b;
  logic          ld_mode = 1'b0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic [AW:0]   ld_count;
  logic          busy;

  cpu_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .NOP_WORD(8'h00)) dut (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .instr_out(instr_out),
    .addr_b(addr_b), .we_b(we_b), .write_data_b(write_data_b), .data_out_b(data_out_b),
    .ld_mode(ld_mode), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_count(ld_count), .busy(busy)
  );

  // Reference model: expected array contents and load count
  logic [DW-1:0] ref_mem [DEPTH];
  int            ld_cnt_m = 0;
  logic [DW-1:0] lq_a[$];
  logic [DW-1:0] lq_d[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_b = 1'b0; ld_mode = 1'b0; ld_valid = 1'b0;
  endtask

  // Hold reset for n edges, check reset outputs, release; the model expects
  // an all-zero array once the clear sweep finishes.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    check("rst_busy", busy, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_ld_count", ld_count, 0);
    check("rst_instr", instr_out, 8'h00);
    check("rst_data", data_out_b, 8'h00);
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ld_cnt_m = 0;
  endtask

  // Count cycles until busy falls; the sweep must take exactly DEPTH cycles.
  task automatic wait_clear();
    int c = 0;
    while (busy === 1'b1 && c < 400) begin
      step();
      c++;
      check("clear_instr", instr_out, 8'h00);
    end
    check("clear_len", c, DEPTH);
  endtask

  // One RUN cycle with port A read and port B read/write, write-first.
  task automatic run_cycle(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic we, input logic [DW-1:0] wd);
    logic [DW-1:0] exp_i;
    logic [DW-1:0] exp_b;
    exp_i = (we && a == b) ? wd : ref_mem[a];
    exp_b = we ? wd : ref_mem[b];
    addr_a = a; addr_b = b; we_b = we; write_data_b = wd;
    step();
    if (we) ref_mem[b] = wd;
    check("run_instr", instr_out, exp_i);
    check("run_data", data_out_b, exp_b);
    check("run_busy", busy, 0);
    check("run_ld_count", ld_count, ld_cnt_m);
    we_b = 1'b0;
  endtask

  // Enter LOAD, push the beats queued in lq_a/lq_d, and leave. exit_last
  // drops ld_mode on the final beat. A stray store to address 5 rides along
  // every beat and must never land.
  task automatic load_session(input bit exit_last);
    bit last;
    we_b = 1'b0; ld_valid = 1'b0; ld_mode = 1'b1;
    step();
    ld_cnt_m = 0;
    check("ld_enter_busy", busy, 1);
    check("ld_enter_ready", ld_ready, 1);
    check("ld_enter_count", ld_count, 0);
    check("ld_enter_instr", instr_out, 8'h00);
    for (int i = 0; i < lq_a.size(); i++) begin
      last = (i == lq_a.size() - 1);
      ld_valid = 1'b1; ld_addr = lq_a[i]; ld_data = lq_d[i];
      we_b = 1'b1; addr_b = 8'h05; write_data_b = 8'($urandom);
      ld_mode = !(exit_last && last);
      step();
      ref_mem[lq_a[i]] = lq_d[i];
      if (ld_cnt_m < DEPTH) ld_cnt_m++;
      check("ld_count", ld_count, ld_cnt_m);
      check("ld_instr_nop", instr_out, 8'h00);
      check("ld_data_zero", data_out_b, 8'h00);
      check("ld_busy", busy, ld_mode);
      check("ld_ready", ld_ready, ld_mode);
    end
    ld_valid = 1'b0; we_b = 1'b0;
    if (!exit_last) begin
      ld_mode = 1'b0;
      step();
      check("ld_exit_busy", busy, 0);
      check("ld_exit_ready", ld_ready, 0);
      check("ld_exit_count", ld_count, ld_cnt_m);
      check("ld_exit_instr", instr_out, 8'h00);
    end
    lq_a.delete();
    lq_d.delete();
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] prog [12];
    prog = '{8'h00, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 8'h65, 8'h81, 8'h85, 8'h89, 8'h8D, 8'h00};

    // Reset and clear sweep; every word must read back zero.
    do_reset(2);
    wait_clear();
    for (int i = 0; i < DEPTH; i++) run_cycle(AW'(i), AW'(DEPTH - 1 - i), 1'b0, 8'h00);

    // Reset partway through the sweep restarts it from address 0.
    do_reset(1);
    repeat (100) step();
    do_reset(1);
    wait_clear();

    // Directed program load of 12 bytes, then fetch them back.
    for (int i = 0; i < 12; i++) begin lq_a.push_back(8'(i)); lq_d.push_back(prog[i]); end
    load_session(1'b0);
    check("prog_count", ld_count, 12);
    for (int i = 0; i < 12; i++) run_cycle(AW'(i), 8'h80, 1'b0, 8'h00);

    // Store then load back; the neighbouring word stays zero.
    run_cycle(8'h00, 8'h40, 1'b1, 8'hA5);
    run_cycle(8'h00, 8'h40, 1'b0, 8'h00);
    run_cycle(8'h00, 8'h41, 1'b0, 8'h00);

    // Same-cycle fetch and store to one address: write-first on both ports.
    run_cycle(8'h10, 8'h10, 1'b1, 8'h3C);
    run_cycle(8'h10, 8'h10, 1'b0, 8'h00);

    // Stores issued during LOAD are dropped; address 5 keeps its program byte.
    lq_a.push_back(8'h20); lq_d.push_back(8'h77);
    load_session(1'b1);
    run_cycle(8'h05, 8'h05, 1'b0, 8'h00);
    run_cycle(8'h20, 8'h05, 1'b0, 8'h00);

    // Randomized RUN traffic over a narrow address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      run_cycle(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Randomized load sessions with repeated addresses, then read back.
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        lq_a.push_back(8'($urandom_range(0, 31)));
        lq_d.push_back(8'($urandom));
      end
      load_session(1'($urandom_range(0, 1)));
      for (int i = 0; i < 32; i++) run_cycle(AW'(i), AW'(31 - i), 1'b0, 8'h00);
    end

    // Count saturates at DEPTH.
    for (int i = 0; i < 260; i++) begin
      lq_a.push_back(8'($urandom));
      lq_d.push_back(8'($urandom));
    end
    load_session(1'b1);
    check("sat_count", ld_count, 256);
    for (int i = 0; i < 8; i++) run_cycle(8'($urandom), 8'($urandom), 1'b0, 8'h00);

    // Reset during LOAD aborts the session and wipes the loaded bytes.
    for (int i = 0; i < 4; i++) begin lq_a.push_back(8'(8'hC0 + i)); lq_d.push_back(8'(8'hE0 + i)); end
    ld_mode = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = lq_a[i]; ld_data = lq_d[i];
      step();
    end
    lq_a.delete();
    lq_d.delete();
    check("pre_rst_count", ld_count, 4);
    ld_valid = 1'b1; ld_mode = 1'b1; we_b = 1'b1; addr_b = 8'hC0; write_data_b = 8'h99;
    do_reset(1);
    wait_clear();
    for (int i = 0; i < 4; i++) run_cycle(8'(8'hC0 + i), 8'(8'hC3 - i), 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the single-cycle CPU's two memory interfaces: port A serves instruction fetch and port B serves data read/write. It backs both ports with one shared DEPTH x DATA_W array and returns synchronous reads with 1-cycle latency. It also runs two maintenance modes from an internal FSM:
- a hardware clear sequence after reset;
- a byte-wide program-load mode, used by benches and the boot path.

While either mode is active, the CPU must be held off.

Parameters:
ADDR_W, 8, address width of all ports
DATA_W, 8, data width
DEPTH, 2**ADDR_W, number of words; the clear sequence walks all of them
NOP_WORD, 8'h00, value driven on instr_out while busy

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
addr_a  in  ADDR_W  fetch address (CPU PC)
instr_out  out  DATA_W  fetched instruction, registered
addr_b  in  ADDR_W  data address
we_b  in  1  data write enable
write_data_b  in  DATA_W  data write value
data_out_b  out  DATA_W  data read value, registered
ld_mode  in  1  request program-load mode
ld_valid  in  1  loader byte valid
ld_addr  in  ADDR_W  loader write address
ld_data  in  DATA_W  loader write data
ld_ready  out  1  loader may present bytes
ld_count  out  ADDR_W+1  bytes accepted in the current load session
busy  out  1  CLEAR or LOAD in progress; CPU must stall

Behaviour:
Reset (rst=1 at an edge):
- state<=CLEAR, clr_ptr<=0
- instr_out<=NOP_WORD, data_out_b<=0
- busy<=1, ld_ready<=0, ld_count<=0
- Array contents are not reset directly; CLEAR zeroes them.

FSM states: CLEAR, RUN, LOAD.

CLEAR:
- Each cycle writes 0 to mem[clr_ptr], then clr_ptr++.
- After the write to DEPTH-1, the next state is RUN. CLEAR therefore lasts exactly DEPTH cycles after rst deasserts.
- busy=1 for the whole state; it drops in the first RUN cycle.
- Port A/B and loader inputs are ignored.
- ld_mode high during CLEAR is held pending and honoured on entry to RUN.

RUN:
- Port A read: instr_out(n+1) = mem[addr_a(n)].
- Port B read: data_out_b(n+1) = mem[addr_b(n)].
- Port B write: if we_b(n), mem[addr_b(n)] <= write_data_b(n) at that edge.
- Same-cycle collisions are write-first: if we_b and addr_a==addr_b, instr_out(n+1) = write_data_b(n); data_out_b(n+1) = write_data_b(n) likewise.
- ld_mode=1 moves to LOAD at the next edge. That edge still performs any RUN-cycle port B write. ld_count<=0.

LOAD:
- busy=1, ld_ready=1.
- instr_out=NOP_WORD and data_out_b=0 each cycle. we_b is suppressed (no array write).
- If ld_valid&ld_ready: mem[ld_addr]<=ld_data and ld_count++. ld_count saturates at DEPTH.
- Repeated writes to the same address: the last one wins.
- ld_mode=0 returns to RUN at the next edge. A beat with ld_valid on that same cycle is still accepted. ld_ready drops with the state change.
- The first RUN cycle after LOAD issues a normal fetch; instr_out is valid one cycle later.
- ld_count holds its value after exit until the next LOAD entry.

Address wrap: addresses are modulo DEPTH with no out-of-range detection. When ADDR_W=8, ld_count width 9 allows a count of 256.

Reset mid-CLEAR: restarts at clr_ptr=0.

Reset mid-LOAD: the session is aborted, the state returns to CLEAR, and all loaded bytes are zeroed. ld_count<=0.

rst has priority over every other input, including ld_mode, ld_valid and we_b in the same cycle.

Test Plan:
1. rst high 2 cycles, then low → busy=1 for exactly 256 cycles, then 0. Backdoor-read of every mem word returns 8'h00. instr_out=8'h00 throughout.
2. After CLEAR, set ld_mode=1 and load bytes {00,21,31,41,51,61,65,81,85,89,8D,00} at addresses 0..11 with ld_valid every cycle, then ld_mode=0 → ld_count=12. In RUN, addr_a=0..11 yields instr_out equal to those bytes, each one cycle after its address.
3. In RUN, write we_b=1 addr_b=8'h40 data=8'hA5; next cycle we_b=0 addr_b=8'h40 → data_out_b=8'hA5 one cycle later. Address 8'h41 still reads 00.
4. Same cycle: we_b=1, addr_a=addr_b=8'h10, data=8'h3C → instr_out=8'h3C and data_out_b=8'h3C next cycle (write-first).
5. In LOAD, assert we_b=1 addr_b=5 data=8'hFF → no write; after exit, mem[5] is unchanged. instr_out=00 while busy.
6. Load 4 bytes, then rst=1 while ld_valid=1 and ld_mode=1 → state CLEAR, ld_count=0, ld_ready=0; after 256 cycles the loaded addresses read 00.
